// File: rtl/regfile_scoreboard_if.sv
// Register file access bundle: read ports, issue, writeback, debug, ready.
// master = decode/writeback side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data,
        output rs1_addr, rs2_addr, issue_valid, issue_rd,
        output wb_en, wb_rd, wb_data, dbg_addr
    );

    modport slave (
        output ready, rs1_data, rs2_data, rs1_busy, rs2_busy, dbg_data,
        input  rs1_addr, rs2_addr, issue_valid, issue_rd,
        input  wb_en, wb_rd, wb_data, dbg_addr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file: 2 async reads, 1 write, x0 zero, wb bypass,
// pending-writer scoreboard and post-reset clear sequence.
// Ports: clk, reset (sync, active-high), rf_io (slave side of the bundle).
module regfile_scoreboard #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int ZERO_X0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_scoreboard_if.slave   rf_io
);
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            run;
    logic            wb_ok;
    logic            iss_ok;
    logic            hit1;
    logic            hit2;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    function automatic logic is_x0(input logic [AW-1:0] a);
        return (ZERO_X0 != 0) && (a == '0);
    endfunction

    assign run    = (state_q == RUN);
    assign wb_ok  = run && rf_io.wb_en && !is_x0(rf_io.wb_rd);
    assign iss_ok = run && rf_io.issue_valid && !is_x0(rf_io.issue_rd);

    // wb_ok already excludes x0, so bypass never applies to it.
    assign hit1 = (BYPASS != 0) && wb_ok && (rf_io.wb_rd == rf_io.rs1_addr);
    assign hit2 = (BYPASS != 0) && wb_ok && (rf_io.wb_rd == rf_io.rs2_addr);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = rf_io.wb_rd;
        mem_wdata = rf_io.wb_data;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = wb_ok;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Issue applied after writeback so a new producer wins on the same rd.
    always_comb begin
        busy_d = busy_q;
        if (wb_ok) begin
            busy_d[rf_io.wb_rd] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[rf_io.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Storage has no reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rf_io.rs1_data = '0;
        rf_io.rs2_data = '0;
        rf_io.dbg_data = '0;
        if (run) begin
            if (hit1) begin
                rf_io.rs1_data = rf_io.wb_data;
            end else if (!is_x0(rf_io.rs1_addr)) begin
                rf_io.rs1_data = regs_q[rf_io.rs1_addr];
            end
            if (hit2) begin
                rf_io.rs2_data = rf_io.wb_data;
            end else if (!is_x0(rf_io.rs2_addr)) begin
                rf_io.rs2_data = regs_q[rf_io.rs2_addr];
            end
            if (!is_x0(rf_io.dbg_addr)) begin
                rf_io.dbg_data = regs_q[rf_io.dbg_addr];
            end
        end
    end

    assign rf_io.rs1_busy = run && busy_q[rf_io.rs1_addr] && !hit1;
    assign rf_io.rs2_busy = run && busy_q[rf_io.rs2_addr] && !hit2;
    assign rf_io.ready    = run;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, random vs model,
// clear/abort sequences and a no-bypass, ordinary-x0 configuration.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(64), .AW(5)) ifa ();
    regfile_scoreboard_if #(.XLEN(32), .AW(4)) ifb ();

    regfile_scoreboard #(
        .XLEN(64), .NREG(32), .ZERO_X0(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .rf_io(ifa)
    );

    regfile_scoreboard #(
        .XLEN(32), .NREG(16), .ZERO_X0(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .rf_io(ifb)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wrd;
        logic [63:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  ad;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
        logic [63:0] ed;
    } vec_t;

    vec_t        tbl [11];
    logic [63:0] mreg [32];
    bit          mbusy [32];

    function automatic vec_t mk(
        input logic we, input logic [4:0] wrd, input logic [63:0] wd,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
        input logic [63:0] e1, input logic [63:0] e2,
        input logic eb1, input logic eb2, input logic [63:0] ed);
        vec_t v;
        v.we = we; v.wrd = wrd; v.wd = wd; v.iv = iv; v.ird = ird;
        v.a1 = a1; v.a2 = a2; v.ad = ad;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_a(
        input logic we, input logic [4:0] wrd, input logic [63:0] wd,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        ifa.wb_en = we; ifa.wb_rd = wrd; ifa.wb_data = wd;
        ifa.issue_valid = iv; ifa.issue_rd = ird;
        ifa.rs1_addr = a1; ifa.rs2_addr = a2; ifa.dbg_addr = ad;
    endtask

    // Reference behaviour: x0 is zero, a same-cycle write is visible
    // on read ports, and it also resolves a pending hazard.
    function automatic logic [63:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (ifa.wb_en && ifa.wb_rd == a) return ifa.wb_data;
        return mreg[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (ifa.wb_en && ifa.wb_rd == a) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic commit_a();
        @(posedge clk);
        if (ifa.wb_en && ifa.wb_rd != 5'd0) begin
            mreg[ifa.wb_rd]  = ifa.wb_data;
            mbusy[ifa.wb_rd] = 1'b0;
        end
        if (ifa.issue_valid && ifa.issue_rd != 5'd0) begin
            mbusy[ifa.issue_rd] = 1'b1;
        end
    endtask

    task automatic reset_and_clear(input bit abort_mid);
        @(negedge clk);
        reset = 1'b1;
        drive_a(1'b1, 5'd1, '1, 1'b1, 5'd3, 5'd9, 5'd3, 5'd9);
        @(negedge clk);
        chk("reset ready_a", 64'(ifa.ready), 64'd0);
        chk("reset ready_b", 64'(ifb.ready), 64'd0);
        reset = 1'b0;
        if (abort_mid) begin
            repeat (10) @(negedge clk);
            chk("midclr ready_a", 64'(ifa.ready), 64'd0);
            reset = 1'b1;
            @(negedge clk);
            chk("abort ready_a", 64'(ifa.ready), 64'd0);
            reset = 1'b0;
        end
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clr ready_a e%0d", i), 64'(ifa.ready),
                64'(i == 32));
            chk($sformatf("clr ready_b e%0d", i), 64'(ifb.ready),
                64'(i >= 16));
            if (i == 20) begin
                chk("clr rs1_data", ifa.rs1_data, 64'd0);
                chk("clr rs2_busy", 64'(ifa.rs2_busy), 64'd0);
                chk("clr dbg_data", ifa.dbg_data, 64'd0);
            end
        end
        drive_a(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int r = 0; r < 32; r++) begin
            mreg[r]  = '0;
            mbusy[r] = 1'b0;
        end
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            ifa.dbg_addr = 5'(r);
            ifa.rs1_addr = 5'(r);
            #2;
            chk($sformatf("post clr dbg r%0d", r), ifa.dbg_data, 64'd0);
            chk($sformatf("post clr busy r%0d", r),
                64'(ifa.rs1_busy), 64'd0);
        end
    endtask

    initial begin
        drive_a(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        ifb.wb_en = 1'b0; ifb.wb_rd = '0; ifb.wb_data = '0;
        ifb.issue_valid = 1'b0; ifb.issue_rd = '0;
        ifb.rs1_addr = '0; ifb.rs2_addr = '0; ifb.dbg_addr = '0;

        tbl[0]  = mk(1, 5, 64'hDEADBEEF, 0, 0, 0, 5, 5,
                     64'h0, 64'hDEADBEEF, 0, 0, 64'h0);
        tbl[1]  = mk(0, 0, 64'h0, 0, 0, 5, 5, 5,
                     64'hDEADBEEF, 64'hDEADBEEF, 0, 0, 64'hDEADBEEF);
        tbl[2]  = mk(0, 0, 64'h0, 1, 7, 7, 5, 7,
                     64'h0, 64'hDEADBEEF, 0, 0, 64'h0);
        tbl[3]  = mk(0, 0, 64'h0, 0, 0, 7, 7, 7,
                     64'h0, 64'h0, 1, 1, 64'h0);
        tbl[4]  = mk(1, 7, 64'h42, 0, 0, 7, 7, 7,
                     64'h42, 64'h42, 0, 0, 64'h0);
        tbl[5]  = mk(1, 7, 64'h43, 1, 7, 7, 5, 5,
                     64'h43, 64'hDEADBEEF, 0, 0, 64'hDEADBEEF);
        tbl[6]  = mk(0, 0, 64'h0, 0, 0, 7, 7, 7,
                     64'h43, 64'h43, 1, 1, 64'h43);
        tbl[7]  = mk(1, 0, 64'h1234, 1, 0, 0, 0, 0,
                     64'h0, 64'h0, 0, 0, 64'h0);
        tbl[8]  = mk(0, 0, 64'h0, 0, 0, 0, 0, 0,
                     64'h0, 64'h0, 0, 0, 64'h0);
        tbl[9]  = mk(1, 7, 64'h55, 0, 0, 7, 7, 7,
                     64'h55, 64'h55, 0, 0, 64'h43);
        tbl[10] = mk(0, 0, 64'h0, 0, 0, 7, 0, 7,
                     64'h55, 64'h0, 0, 0, 64'h55);

        reset_and_clear(1'b0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_a(tbl[i].we, tbl[i].wrd, tbl[i].wd, tbl[i].iv,
                    tbl[i].ird, tbl[i].a1, tbl[i].a2, tbl[i].ad);
            #2;
            chk($sformatf("tbl%0d ready", i), 64'(ifa.ready), 64'd1);
            chk($sformatf("tbl%0d rs1_data", i), ifa.rs1_data, tbl[i].e1);
            chk($sformatf("tbl%0d rs2_data", i), ifa.rs2_data, tbl[i].e2);
            chk($sformatf("tbl%0d rs1_busy", i), 64'(ifa.rs1_busy),
                64'(tbl[i].eb1));
            chk($sformatf("tbl%0d rs2_busy", i), 64'(ifa.rs2_busy),
                64'(tbl[i].eb2));
            chk($sformatf("tbl%0d dbg_data", i), ifa.dbg_data, tbl[i].ed);
            commit_a();
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_a(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    {$urandom, $urandom},
                    1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)));
            #2;
            chk($sformatf("rnd%0d rs1_data", i), ifa.rs1_data,
                m_rd(ifa.rs1_addr));
            chk($sformatf("rnd%0d rs2_data", i), ifa.rs2_data,
                m_rd(ifa.rs2_addr));
            chk($sformatf("rnd%0d rs1_busy", i), 64'(ifa.rs1_busy),
                64'(m_busy(ifa.rs1_addr)));
            chk($sformatf("rnd%0d rs2_busy", i), 64'(ifa.rs2_busy),
                64'(m_busy(ifa.rs2_addr)));
            chk($sformatf("rnd%0d dbg_data", i), ifa.dbg_data,
                (ifa.dbg_addr == 5'd0) ? 64'd0 : mreg[ifa.dbg_addr]);
            commit_a();
        end

        reset_and_clear(1'b1);

        @(negedge clk);
        ifb.wb_en = 1'b1; ifb.wb_rd = 4'd3; ifb.wb_data = 32'hFFFFFFFF;
        ifb.rs1_addr = 4'd3; ifb.rs2_addr = 4'd1; ifb.dbg_addr = 4'd3;
        #2;
        chk("b nobyp rs1", 64'(ifb.rs1_data), 64'd0);
        chk("b clr r1", 64'(ifb.rs2_data), 64'd0);
        chk("b nobyp dbg", 64'(ifb.dbg_data), 64'd0);
        @(negedge clk);
        ifb.wb_en = 1'b0;
        #2;
        chk("b stored rs1", 64'(ifb.rs1_data), 64'hFFFFFFFF);
        chk("b stored dbg", 64'(ifb.dbg_data), 64'hFFFFFFFF);
        @(negedge clk);
        ifb.wb_en = 1'b1; ifb.wb_rd = 4'd0; ifb.wb_data = 32'hA5A5;
        ifb.issue_valid = 1'b1; ifb.issue_rd = 4'd0;
        ifb.rs1_addr = 4'd0;
        #2;
        chk("b r0 nobyp", 64'(ifb.rs1_data), 64'd0);
        @(negedge clk);
        ifb.wb_en = 1'b0; ifb.issue_valid = 1'b0;
        #2;
        chk("b r0 data", 64'(ifb.rs1_data), 64'hA5A5);
        chk("b r0 busy", 64'(ifb.rs1_busy), 64'd1);
        @(negedge clk);
        ifb.wb_en = 1'b1; ifb.wb_rd = 4'd0; ifb.wb_data = 32'h77;
        #2;
        chk("b wb cyc data", 64'(ifb.rs1_data), 64'hA5A5);
        chk("b wb cyc busy", 64'(ifb.rs1_busy), 64'd1);
        @(negedge clk);
        ifb.wb_en = 1'b0;
        #2;
        chk("b after wb data", 64'(ifb.rs1_data), 64'h77);
        chk("b after wb busy", 64'(ifb.rs1_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
